// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if
//   Groups the key level and the classified event outputs of the key event
//   decoder into one bundle.
//   slave  : the decoder side (consumes signal, drives all event outputs).
//   master : the producer/observer side (drives signal, reads events).
//   Signals:
//     signal        debounced key level, synchronous to clk
//     press_pulse   one-cycle pulse on each press edge
//     release_pulse one-cycle pulse on each release edge
//     short_press   one-cycle pulse: single short press confirmed
//     long_press    one-cycle pulse: hold reached LONG_CYCLES
//     double_click  one-cycle pulse: two short presses within the gap
//     held          level, high while the long hold is in progress
//     repeat_pulse  auto-repeat pulse during a long hold (optional build)
interface key_event_decoder_if;
  logic signal;
  logic press_pulse;
  logic release_pulse;
  logic short_press;
  logic long_press;
  logic double_click;
  logic held;
  logic repeat_pulse;

  modport master (
    output signal,
    input  press_pulse, release_pulse, short_press, long_press,
           double_click, held, repeat_pulse
  );

  modport slave (
    input  signal,
    output press_pulse, release_pulse, short_press, long_press,
           double_click, held, repeat_pulse
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Classifies a debounced key level into single-cycle gesture events:
//   press, release, short press, long press and double click, plus a
//   "held" level during a long hold. All outputs are registered.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    key_event_decoder_if.slave (signal in, event outputs)
//   Build option:
//     KEY_REPEAT_EN  when defined, repeat_pulse fires every REPEAT_CYCLES
//                    while in the long hold; otherwise it is tied to 0.
//   LONG_CYCLES, GAP_CYCLES and REPEAT_CYCLES must each be at least 2.
module key_event_decoder #(
  parameter logic        ACTIVE_LEVEL  = 1'b1,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned GAP_CYCLES    = 15000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned CNT_W         = 26
) (
  input logic               clk,
  input logic               rst_n,
  key_event_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  // Each classified pulse is registered on the edge where the timer steps
  // onto its terminal value; the state change follows on the next edge.
  localparam logic [CNT_W-1:0] LONG_FIRE = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_FIRE  = CNT_W'(GAP_CYCLES - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q;
  logic             prev_q;
  logic             pend_q, pend_d;
  logic             press_q, release_q;
  logic             short_q, long_q, double_q, held_q;
  logic             short_d, long_d, double_d;
  logic             level, press_edge, release_edge;

  assign level        = (bus.signal == ACTIVE_LEVEL);
  assign press_edge   = level & ~prev_q;
  assign release_edge = ~level & prev_q;

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    pend_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // pend_q carries a press that landed on the gap timeout edge.
        if (press_edge || (pend_q && level)) state_d = PRESSED;
      end
      PRESSED, SECOND_PRESSED: begin
        if (timer_q == LONG_LAST) begin
          state_d = release_edge ? IDLE : LONG_HELD;
        end else if (release_edge) begin
          if (state_q == PRESSED) begin
            state_d = WAIT_SECOND;
          end else begin
            state_d  = IDLE;
            double_d = 1'b1;
          end
        end else if (timer_q == LONG_FIRE) begin
          long_d = 1'b1;
        end
      end
      LONG_HELD: begin
        if (release_edge) state_d = IDLE;
      end
      WAIT_SECOND: begin
        if (timer_q == GAP_LAST) begin
          state_d = IDLE;
          pend_d  = press_edge;
        end else if (press_edge) begin
          state_d = SECOND_PRESSED;
        end else if (timer_q == GAP_FIRE) begin
          short_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      prev_q    <= 1'b0;
      pend_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= (state_d != state_q) ? '0 : timer_q + 1'b1;
      prev_q    <= level;
      pend_q    <= pend_d;
      press_q   <= press_edge;
      release_q <= release_edge;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
      held_q    <= (state_d == LONG_HELD);
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_press   = short_q;
  assign bus.long_press    = long_q;
  assign bus.double_click  = double_q;
  assign bus.held          = held_q;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_FIRE = CNT_W'(REPEAT_CYCLES - 2);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_timer_q;
  logic             rep_q;

  // Modulo-REPEAT_CYCLES counter restarted on entry to LONG_HELD; the pulse
  // is suppressed on the edge that leaves the hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_timer_q <= '0;
      rep_q       <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (state_d == LONG_HELD && state_q != LONG_HELD) begin
        rep_timer_q <= '0;
      end else if (state_q == LONG_HELD) begin
        rep_timer_q <= (rep_timer_q == REP_LAST) ? '0 : rep_timer_q + 1'b1;
        rep_q       <= (state_d == LONG_HELD) && (rep_timer_q == REP_FIRE);
      end
    end
  end

  assign bus.repeat_pulse = rep_q;
`else
  assign bus.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder
//   Drives a key-level timeline (directed gestures followed by random
//   press/release runs) into key_event_decoder and compares every output on
//   every cycle against an event list derived from gesture timing rules.
//   Build option KEY_REPEAT_EN is honoured the same way as in the design.
module tb_key_event_decoder;
  localparam int N = 3000;
  localparam int L = 20;
  localparam int G = 10;
  localparam int R = 8;

  logic clk;
  logic rst_n;
  key_event_decoder_if kif ();

  key_event_decoder #(
    .ACTIVE_LEVEL (1'b1),
    .LONG_CYCLES  (L),
    .GAP_CYCLES   (G),
    .REPEAT_CYCLES(R),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  bit stim [N];
  bit e_pp [N], e_rp [N], e_sp [N], e_lp [N], e_dc [N], e_hd [N], e_rep [N];
  bit d_pp [N], d_rp [N], d_sp [N], d_lp [N], d_dc [N], d_hd [N], d_rep [N];

  task automatic chk(input string nm, input int t, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0d got=%b want=%b", nm, t, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm, input int t);
    chk({nm, ".press_pulse"},   t, kif.press_pulse,   1'b0);
    chk({nm, ".release_pulse"}, t, kif.release_pulse, 1'b0);
    chk({nm, ".short_press"},   t, kif.short_press,   1'b0);
    chk({nm, ".long_press"},    t, kif.long_press,    1'b0);
    chk({nm, ".double_click"},  t, kif.double_click,  1'b0);
    chk({nm, ".held"},          t, kif.held,          1'b0);
    chk({nm, ".repeat_pulse"},  t, kif.repeat_pulse,  1'b0);
  endtask

  function automatic bit rise_at(input int t);
    return stim[t] && (t == 0 || !stim[t-1]);
  endfunction

  function automatic int next_fall(input int t);
    for (int k = t + 1; k < N; k++) if (!stim[k]) return k;
    return N;
  endfunction

  function automatic int next_rise(input int t);
    for (int k = t; k < N; k++) if (rise_at(k)) return k;
    return N;
  endfunction

  // A press starting at tp and released at tr with tr >= tp+L: long pulse
  // L-1 edges after the press, held until the release, repeats every R.
  task automatic mark_long(input int tp, input int tr);
    if (tp + L - 1 < N) e_lp[tp+L-1] = 1'b1;
    for (int e = tp + L; e < tr && e < N; e++) e_hd[e] = 1'b1;
`ifdef KEY_REPEAT_EN
    for (int e = tp + L + R - 1; e < tr && e < N; e += R) e_rep[e] = 1'b1;
`endif
  endtask

  // Expected output after edge t, derived from gesture timing on the
  // recorded key timeline.
  task automatic build_model();
    int t, tp, tr, t2;
    bit second;
    for (int k = 0; k < N; k++) begin
      e_pp[k] = rise_at(k);
      e_rp[k] = !stim[k] && k > 0 && stim[k-1];
    end
    t = 0;
    while (t < N) begin
      if (!rise_at(t)) begin
        t++;
        continue;
      end
      tp = t;
      second = 1'b0;
      while (1) begin
        tr = next_fall(tp);
        if (tr >= tp + L) begin
          mark_long(tp, tr);
          t = tr + 1;
          break;
        end
        if (tr >= N) begin
          t = N;
          break;
        end
        if (second) begin
          e_dc[tr] = 1'b1;
          t = tr + 1;
          break;
        end
        t2 = next_rise(tr + 1);
        if (t2 <= tr + G - 1) begin
          tp = t2;
          second = 1'b1;
          continue;
        end
        if (tr + G - 1 < N) e_sp[tr+G-1] = 1'b1;
        // Press on the timeout edge: handled as a fresh press one edge later.
        if (t2 == tr + G && tr + G + 1 < N && stim[tr+G+1]) begin
          tp = tr + G + 1;
          second = 1'b0;
          continue;
        end
        t = tr + G + 1;
        break;
      end
    end
  endtask

  task automatic set_hi(input int a, input int b);
    for (int k = a; k <= b; k++) stim[k] = 1'b1;
  endtask

  initial begin
    int t, hi, lo;
    rst_n      = 1'b0;
    kif.signal = 1'b0;

    // Directed gestures.
    set_hi(10, 14);               // short press
    set_hi(110, 165);             // long press with repeats
    set_hi(200, 202);             // double click, first press
    set_hi(207, 209);             // double click, second press
    set_hi(250, 252);             // gap boundary, first press
    set_hi(263, 267);             // press exactly on the gap timeout edge
    // Random press/release runs.
    t = 300;
    while (t < N - 100) begin
      hi = $urandom_range(2, 45);
      set_hi(t, t + hi - 1);
      t += hi;
      lo = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 40) : $urandom_range(2, 16);
      t += lo;
    end
    build_model();

    // Reset behaviour.
    #12;
    chk_all_zero("in_reset", -1);
    @(negedge clk);
    rst_n      = 1'b1;
    kif.signal = 1'b1;
    @(posedge clk); #1;
    chk("first_press", -1, kif.press_pulse, 1'b1);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;                 // asynchronous, mid-press
    #1;
    chk_all_zero("async_reset", -1);
    @(negedge clk);
    rst_n = 1'b1;                 // key still held
    @(posedge clk); #1;
    chk("held_thru_reset", -1, kif.press_pulse, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    kif.signal = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      chk_all_zero("post_reset_quiet", k);
    end

    // Timeline, compared every cycle.
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      kif.signal = stim[k];
      @(posedge clk); #1;
      d_pp[k] = kif.press_pulse;   d_rp[k] = kif.release_pulse;
      d_sp[k] = kif.short_press;   d_lp[k] = kif.long_press;
      d_dc[k] = kif.double_click;  d_hd[k] = kif.held;
      d_rep[k] = kif.repeat_pulse;
      chk("press_pulse",   k, kif.press_pulse,   e_pp[k]);
      chk("release_pulse", k, kif.release_pulse, e_rp[k]);
      chk("short_press",   k, kif.short_press,   e_sp[k]);
      chk("long_press",    k, kif.long_press,    e_lp[k]);
      chk("double_click",  k, kif.double_click,  e_dc[k]);
      chk("held",          k, kif.held,          e_hd[k]);
      chk("repeat_pulse",  k, kif.repeat_pulse,  e_rep[k]);
      chk("exclusive", k,
          (int'(kif.short_press) + int'(kif.long_press) + int'(kif.double_click)) <= 1,
          1'b1);
    end

    // Hand-computed anchor points.
    chk("pin_short_pp",  10,  d_pp[10],  1'b1);
    chk("pin_short_rp",  15,  d_rp[15],  1'b1);
    chk("pin_short_sp",  24,  d_sp[24],  1'b1);
    chk("pin_long_lp",   129, d_lp[129], 1'b1);
    chk("pin_held_on",   130, d_hd[130], 1'b1);
    chk("pin_held_last", 165, d_hd[165], 1'b1);
    chk("pin_held_off",  166, d_hd[166], 1'b0);
    chk("pin_long_nosp", 174, d_sp[174], 1'b0);
    chk("pin_double",    210, d_dc[210], 1'b1);
    chk("pin_dbl_nosp",  212, d_sp[212], 1'b0);
    chk("pin_gap_sp",    262, d_sp[262], 1'b1);
    chk("pin_gap_pp",    263, d_pp[263], 1'b1);
    chk("pin_gap_sp2",   277, d_sp[277], 1'b1);
    chk("pin_gap_nodc",  268, d_dc[268], 1'b0);
`ifdef KEY_REPEAT_EN
    chk("pin_rep_first", 137, d_rep[137], 1'b1);
    chk("pin_rep_mid",   145, d_rep[145], 1'b1);
    chk("pin_rep_last",  161, d_rep[161], 1'b1);
    chk("pin_rep_after", 169, d_rep[169], 1'b0);
`else
    begin
      int ones;
      ones = 0;
      for (int k = 0; k < N; k++) ones += int'(d_rep[k]);
      compared++;
      if (ones != 0) begin
        mismatched++;
        $display("FAIL repeat_tied_off got=%0d pulses want=0", ones);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
